// File: rtl/tlb_miss_ctrl.sv
// TLB refill sequencer: detects lookup misses, drives the page table walker,
// and writes the walked translation into a tree-PLRU-selected CAM line.
module tlb_miss_ctrl #(
  parameter int unsigned TLB_ENTRIES = 8,
  parameter int unsigned VPN_BITS    = 27
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   TLBAccess,
  input  logic [VPN_BITS-1:0]    VPN,
  input  logic                   CAMHit,
  input  logic [TLB_ENTRIES-1:0] Matches,
  input  logic                   TLBFlush,
  output logic                   WalkReq,
  output logic [VPN_BITS-1:0]    WalkVPN,
  input  logic                   WalkAck,
  input  logic                   WalkFault,
  input  logic [1:0]             WalkPageType,
  output logic                   WalkAbort,
  output logic [TLB_ENTRIES-1:0] WriteEnables,
  output logic [1:0]             PageTypeWriteVal,
  output logic                   TLBFault,
  output logic                   TLBStall
);

  localparam int unsigned LVL = $clog2(TLB_ENTRIES);

  typedef enum logic [1:0] {IDLE, WALK, WRITE, FAULT} state_e;

  state_e                 state_q, state_d;
  logic [VPN_BITS-1:0]    walk_vpn_q, walk_vpn_d;
  logic [1:0]             ptype_q, ptype_d;
  logic [LVL-1:0]         victim_q, victim_d;
  logic [TLB_ENTRIES-1:1] plru_q, plru_d;
  logic [LVL-1:0]         plru_victim;
  logic [LVL-1:0]         hit_idx;
  logic                   lookup_miss;
  logic                   lookup_hit;

  // Heap-ordered tree: node n has children 2n (lower half) and 2n+1 (upper half).
  function automatic logic [LVL-1:0] pick_victim(input logic [TLB_ENTRIES-1:1] tree);
    logic [LVL:0] node;
    node = (LVL+1)'(1);
    for (int l = 0; l < int'(LVL); l++) begin
      node = {node[LVL-1:0], tree[node[LVL-1:0]]};
    end
    return node[LVL-1:0];
  endfunction

  // Walk from the leaf to the root, pointing every node away from idx.
  function automatic logic [TLB_ENTRIES-1:1] touch(input logic [TLB_ENTRIES-1:1] tree,
                                                    input logic [LVL-1:0] idx);
    logic [TLB_ENTRIES-1:1] t;
    logic [LVL:0]           node;
    t    = tree;
    node = {1'b1, idx};
    for (int l = 0; l < int'(LVL); l++) begin
      t[node[LVL:1]] = ~node[0];
      node = node >> 1;
    end
    return t;
  endfunction

  assign lookup_miss = TLBAccess & ~CAMHit;
  assign lookup_hit  = TLBAccess & CAMHit;
  assign plru_victim = pick_victim(plru_q);

  // Lowest set match index
  always_comb begin
    hit_idx = '0;
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (Matches[i]) hit_idx = LVL'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    walk_vpn_d = walk_vpn_q;
    ptype_d    = ptype_q;
    victim_d   = victim_q;
    plru_d     = plru_q;
    case (state_q)
      IDLE: begin
        if (lookup_miss && !TLBFlush) begin
          walk_vpn_d = VPN;
          state_d    = WALK;
        end else if (lookup_hit) begin
          plru_d = touch(plru_q, hit_idx);
        end
      end
      WALK: begin
        if (TLBFlush) begin
          state_d = IDLE;
        end else if (WalkAck) begin
          if (WalkFault) begin
            state_d = FAULT;
          end else begin
            ptype_d  = WalkPageType;
            victim_d = plru_victim;
            state_d  = WRITE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        plru_d  = touch(plru_q, victim_q);
      end
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush wipes replacement history and wins over any same-cycle touch.
    if (TLBFlush) plru_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      walk_vpn_q <= '0;
      ptype_q    <= '0;
      victim_q   <= '0;
      plru_q     <= '0;
    end else begin
      state_q    <= state_d;
      walk_vpn_q <= walk_vpn_d;
      ptype_q    <= ptype_d;
      victim_q   <= victim_d;
      plru_q     <= plru_d;
    end
  end

  assign WalkReq          = (state_q == WALK);
  assign WalkVPN          = walk_vpn_q;
  assign WalkAbort        = (state_q == WALK) & TLBFlush;
  assign WriteEnables     = (state_q == WRITE && !TLBFlush) ?
                            (TLB_ENTRIES'(1) << victim_q) : '0;
  assign PageTypeWriteVal = (state_q == WRITE) ? ptype_q : 2'b00;
  assign TLBFault         = (state_q == FAULT);
  assign TLBStall         = (state_q != IDLE) | lookup_miss;

endmodule

// File: tb/tb_tlb_miss_ctrl.sv
// Bench for tlb_miss_ctrl: directed refill scenarios plus random hit/miss/flush
// traffic, checked against a range-based pseudo-LRU reference model.
module tb_tlb_miss_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned VB = 27;

  logic          clk;
  logic          reset;
  logic          TLBAccess;
  logic [VB-1:0] VPN;
  logic          CAMHit;
  logic [N-1:0]  Matches;
  logic          TLBFlush;
  logic          WalkReq;
  logic [VB-1:0] WalkVPN;
  logic          WalkAck;
  logic          WalkFault;
  logic [1:0]    WalkPageType;
  logic          WalkAbort;
  logic [N-1:0]  WriteEnables;
  logic [1:0]    PageTypeWriteVal;
  logic          TLBFault;
  logic          TLBStall;

  int n_tests = 0;
  int n_fail  = 0;
  int tree [N];

  tlb_miss_ctrl #(.TLB_ENTRIES(N), .VPN_BITS(VB)) dut (
    .clk(clk), .reset(reset), .TLBAccess(TLBAccess), .VPN(VPN), .CAMHit(CAMHit),
    .Matches(Matches), .TLBFlush(TLBFlush), .WalkReq(WalkReq), .WalkVPN(WalkVPN),
    .WalkAck(WalkAck), .WalkFault(WalkFault), .WalkPageType(WalkPageType),
    .WalkAbort(WalkAbort), .WriteEnables(WriteEnables),
    .PageTypeWriteVal(PageTypeWriteVal), .TLBFault(TLBFault), .TLBStall(TLBStall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference PLRU: tree[node]=1 means the victim lies in the upper half of that node's range.
  function automatic void m_clear();
    for (int i = 0; i < int'(N); i++) tree[i] = 0;
  endfunction

  function automatic int m_victim();
    int node = 1;
    int lo   = 0;
    int size = int'(N);
    while (size > 1) begin
      size = size / 2;
      if (tree[node] != 0) begin
        lo   = lo + size;
        node = 2 * node + 1;
      end else begin
        node = 2 * node;
      end
    end
    return lo;
  endfunction

  function automatic void m_touch(input int e);
    int node = 1;
    int lo   = 0;
    int size = int'(N);
    while (size > 1) begin
      size = size / 2;
      if (e >= lo + size) begin
        tree[node] = 0;
        lo   = lo + size;
        node = 2 * node + 1;
      end else begin
        tree[node] = 1;
        node = 2 * node;
      end
    end
  endfunction

  function automatic int lowest(input logic [N-1:0] m);
    for (int i = 0; i < int'(N); i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic set_idle();
    TLBAccess    = 1'b0;
    VPN          = '0;
    CAMHit       = 1'b0;
    Matches      = '0;
    TLBFlush     = 1'b0;
    WalkAck      = 1'b0;
    WalkFault    = 1'b0;
    WalkPageType = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_clear();
  endtask

  // flush_mode: 0 none, 1 flush on the ack cycle, 2 flush on the write cycle.
  task automatic do_miss(input logic [VB-1:0] vpn, input int delay, input bit fault,
                         input logic [1:0] pt, input int flush_mode, input int exp_v);
    int v;
    v = (exp_v >= 0) ? exp_v : m_victim();
    set_idle();
    TLBAccess = 1'b1;
    VPN       = vpn;
    @(negedge clk);
    check("miss_stall", 32'(TLBStall), 32'd1);
    check("miss_noreq", 32'(WalkReq), 32'd0);
    step();
    for (int d = 0; d < delay; d++) begin
      set_idle();
      TLBAccess = 1'b1;
      VPN       = VB'($urandom());
      Matches   = N'($urandom());
      @(negedge clk);
      check("walk_req", 32'(WalkReq), 32'd1);
      check("walk_vpn", 32'(WalkVPN), 32'(vpn));
      check("walk_stall", 32'(TLBStall), 32'd1);
      check("walk_noabort", 32'(WalkAbort), 32'd0);
      check("walk_nowe", 32'(WriteEnables), 32'd0);
      step();
    end
    set_idle();
    TLBAccess    = 1'b1;
    WalkAck      = 1'b1;
    WalkFault    = fault;
    WalkPageType = pt;
    TLBFlush     = (flush_mode == 1);
    @(negedge clk);
    check("ack_req", 32'(WalkReq), 32'd1);
    check("ack_abort", 32'(WalkAbort), 32'(flush_mode == 1));
    check("ack_nowe", 32'(WriteEnables), 32'd0);
    step();
    if (flush_mode == 1) begin
      m_clear();
    end else if (fault) begin
      set_idle();
      TLBAccess = 1'b1;
      @(negedge clk);
      check("fault_pulse", 32'(TLBFault), 32'd1);
      check("fault_nowe", 32'(WriteEnables), 32'd0);
      check("fault_stall", 32'(TLBStall), 32'd1);
      step();
    end else begin
      set_idle();
      TLBAccess = 1'b1;
      Matches   = N'($urandom());
      TLBFlush  = (flush_mode == 2);
      @(negedge clk);
      check("write_we", 32'(WriteEnables), (flush_mode == 2) ? 32'd0 : (32'd1 << v));
      check("write_pt", 32'(PageTypeWriteVal), 32'(pt));
      check("write_nofault", 32'(TLBFault), 32'd0);
      check("write_stall", 32'(TLBStall), 32'd1);
      step();
      if (flush_mode == 2) m_clear();
      else m_touch(v);
    end
    set_idle();
    @(negedge clk);
    check("done_stall", 32'(TLBStall), 32'd0);
    check("done_req", 32'(WalkReq), 32'd0);
    check("done_we", 32'(WriteEnables), 32'd0);
    check("done_fault", 32'(TLBFault), 32'd0);
    step();
  endtask

  task automatic do_hit(input logic [N-1:0] m);
    set_idle();
    TLBAccess = 1'b1;
    CAMHit    = 1'b1;
    Matches   = m;
    VPN       = VB'($urandom());
    @(negedge clk);
    check("hit_nostall", 32'(TLBStall), 32'd0);
    check("hit_noreq", 32'(WalkReq), 32'd0);
    step();
    m_touch(lowest(m));
  endtask

  task automatic do_flush(input bit access);
    set_idle();
    TLBFlush  = 1'b1;
    TLBAccess = access;
    VPN       = VB'($urandom());
    @(negedge clk);
    check("flush_noabort", 32'(WalkAbort), 32'(0));
    check("flush_stall", 32'(TLBStall), 32'(access));
    step();
    m_clear();
    set_idle();
    @(negedge clk);
    check("flush_noreq", 32'(WalkReq), 32'd0);
    step();
  endtask

  int seq [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

  initial begin
    set_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_clear();
    @(negedge clk);
    check("rst_req", 32'(WalkReq), 32'd0);
    check("rst_vpn", 32'(WalkVPN), 32'd0);
    check("rst_we", 32'(WriteEnables), 32'd0);
    check("rst_pt", 32'(PageTypeWriteVal), 32'd0);
    check("rst_fault", 32'(TLBFault), 32'd0);
    check("rst_abort", 32'(WalkAbort), 32'd0);
    check("rst_stall", 32'(TLBStall), 32'd0);
    step();

    do_miss(VB'(32'h1234), 3, 1'b0, 2'd2, 0, 0);

    do_reset();
    for (int i = 0; i < 9; i++) do_miss(VB'($urandom()), $urandom_range(0, 2), 1'b0,
                                        2'($urandom()), 0, seq[i]);

    do_reset();
    do_miss(VB'($urandom()), 1, 1'b0, 2'd1, 0, 0);
    do_miss(VB'($urandom()), 1, 1'b0, 2'd1, 0, 4);
    do_hit(8'h01);
    do_miss(VB'($urandom()), 1, 1'b0, 2'd3, 0, -1);
    do_hit(8'h04);
    do_miss(VB'($urandom()), 1, 1'b0, 2'd0, 0, -1);

    do_miss(VB'($urandom()), 2, 1'b0, 2'd1, 1, -1);
    do_miss(VB'($urandom()), 0, 1'b0, 2'd2, 0, 0);

    do_miss(VB'($urandom()), 1, 1'b1, 2'd3, 0, -1);
    do_miss(VB'($urandom()), 1, 1'b0, 2'd3, 0, 4);

    do_miss(VB'($urandom()), 1, 1'b0, 2'd2, 2, -1);
    do_miss(VB'($urandom()), 1, 1'b0, 2'd1, 0, 0);

    // Reset while a walk is outstanding
    set_idle();
    TLBAccess = 1'b1;
    VPN       = VB'(32'h0abcd);
    step();
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    check("rstwalk_req_before", 32'(WalkReq), 32'd1);
    step();
    reset = 1'b0;
    m_clear();
    @(negedge clk);
    check("rstwalk_req", 32'(WalkReq), 32'd0);
    check("rstwalk_abort", 32'(WalkAbort), 32'd0);
    check("rstwalk_vpn", 32'(WalkVPN), 32'd0);
    check("rstwalk_we", 32'(WriteEnables), 32'd0);
    check("rstwalk_stall", 32'(TLBStall), 32'd0);
    step();

    for (int it = 0; it < 80; it++) begin
      int r;
      int fm;
      r  = $urandom_range(0, 9);
      fm = $urandom_range(0, 5);
      if (r <= 3) begin
        do_miss(VB'($urandom()), $urandom_range(0, 4), ($urandom_range(0, 5) == 0),
                2'($urandom()), (fm == 4) ? 1 : (fm == 5) ? 2 : 0, -1);
      end else if (r <= 6) begin
        do_hit(N'($urandom_range(1, 255)));
      end else if (r == 7) begin
        do_flush(1'($urandom()));
      end else begin
        set_idle();
        Matches = N'($urandom());
        @(negedge clk);
        check("idle_stall", 32'(TLBStall), 32'd0);
        check("idle_we", 32'(WriteEnables), 32'd0);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
